// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the ID/EX operand stage.
// The master side drives the ID fields and forward sources; the slave is the stage itself.
interface id_ex_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [2:0]      id_alusel;
    logic            id_asel;
    logic            id_bsel;
    logic            id_regwen;
    logic            id_memrd;
    logic            id_memwr;
    logic            hold;
    logic            flush;
    logic [4:0]      exmem_rd;
    logic            exmem_regwen;
    logic [XLEN-1:0] exmem_result;
    logic [4:0]      memwb_rd;
    logic            memwb_regwen;
    logic [XLEN-1:0] memwb_wdata;
    logic            stall_req;
    logic            ex_valid;
    logic            ex_regwen;
    logic            ex_memrd;
    logic            ex_memwr;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic [2:0]      ex_alusel;
    logic [XLEN-1:0] ex_operand1;
    logic [XLEN-1:0] ex_operand2;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alusel, id_asel, id_bsel, id_regwen, id_memrd, id_memwr, hold, flush,
               exmem_rd, exmem_regwen, exmem_result, memwb_rd, memwb_regwen, memwb_wdata,
        input  stall_req, ex_valid, ex_regwen, ex_memrd, ex_memwr, ex_rd, ex_pc, ex_alusel,
               ex_operand1, ex_operand2, ex_store_data
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alusel, id_asel, id_bsel, id_regwen, id_memrd, id_memwr, hold, flush,
               exmem_rd, exmem_regwen, exmem_result, memwb_rd, memwb_regwen, memwb_wdata,
        output stall_req, ex_valid, ex_regwen, ex_memrd, ex_memwr, ex_rd, ex_pc, ex_alusel,
               ex_operand1, ex_operand2, ex_store_data
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, asel/bsel operand muxes
// and load-use hazard detection that stalls ID and drops a bubble into EX.
module id_ex_operand_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    id_ex_operand_stage_if.slave bus
);
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [2:0]      alusel_q;
    logic            asel_q;
    logic            bsel_q;
    logic            regwen_q;
    logic            memrd_q;
    logic            memwr_q;

    logic            load_use;
    logic            bubble;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign load_use = valid_q & memrd_q & (rd_q != 5'd0) & bus.id_valid &
                      ((bus.id_rs1 == rd_q) | (bus.id_rs2 == rd_q));

    // flush beats hold; hold beats the load-use bubble
    assign bubble = bus.flush | (~bus.hold & load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            alusel_q   <= 3'b000;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            regwen_q   <= 1'b0;
            memrd_q    <= 1'b0;
            memwr_q    <= 1'b0;
        end else if (bubble) begin
            valid_q  <= 1'b0;
            rd_q     <= 5'd0;
            alusel_q <= 3'b000;
            regwen_q <= 1'b0;
            memrd_q  <= 1'b0;
            memwr_q  <= 1'b0;
        end else if (!bus.hold) begin
            valid_q    <= bus.id_valid;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
            alusel_q   <= bus.id_alusel;
            asel_q     <= bus.id_asel;
            bsel_q     <= bus.id_bsel;
            regwen_q   <= bus.id_regwen;
            memrd_q    <= bus.id_memrd;
            memwr_q    <= bus.id_memwr;
        end
    end

    // EX/MEM is the younger result, so it is checked first; x0 never forwards
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (bus.exmem_regwen && bus.exmem_rd != 5'd0 && bus.exmem_rd == rs1_q)
            fwd_rs1 = bus.exmem_result;
        else if (bus.memwb_regwen && bus.memwb_rd != 5'd0 && bus.memwb_rd == rs1_q)
            fwd_rs1 = bus.memwb_wdata;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (bus.exmem_regwen && bus.exmem_rd != 5'd0 && bus.exmem_rd == rs2_q)
            fwd_rs2 = bus.exmem_result;
        else if (bus.memwb_regwen && bus.memwb_rd != 5'd0 && bus.memwb_rd == rs2_q)
            fwd_rs2 = bus.memwb_wdata;
    end

    assign bus.stall_req     = load_use;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_regwen     = valid_q & regwen_q;
    assign bus.ex_memrd      = valid_q & memrd_q;
    assign bus.ex_memwr      = valid_q & memwr_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_alusel     = alusel_q;
    assign bus.ex_operand1   = asel_q ? pc_q : fwd_rs1;
    assign bus.ex_operand2   = bsel_q ? imm_q : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-selection stage of the 5-stage RV32I pipeline. Sits directly upstream of the ALU and drives its operand1, operand2 and alusel inputs.
- Captures decoded fields from ID, forwards results from EX/MEM and MEM/WB onto stale register-file operands, and applies the asel/bsel muxes.
- Detects load-use hazards, requests an ID stall and inserts a bubble into EX.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, value of ex_pc after reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_alusel  in  3  ALU opcode, ALU encoding
- id_asel  in  1  0=rs1, 1=pc
- id_bsel  in  1  0=rs2, 1=imm
- id_regwen, id_memrd, id_memwr  in  1  control bits
- hold  in  1  downstream stall: freeze EX register
- flush  in  1  branch mispredict: kill EX next cycle
- exmem_rd  in  5; exmem_regwen  in  1; exmem_result  in  XLEN  EX/MEM forward source
- memwb_rd  in  5; memwb_regwen  in  1; memwb_wdata  in  XLEN  MEM/WB forward source
- stall_req  out  1  load-use: ID/IF must hold
- ex_valid, ex_regwen, ex_memrd, ex_memwr  out  1
- ex_rd  out  5
- ex_pc  out  XLEN
- ex_alusel  out  3
- ex_operand1, ex_operand2  out  XLEN  to ALU
- ex_store_data  out  XLEN  forwarded rs2 for stores

Behaviour:
- Reset (rst_n=0, async): ex_valid, ex_regwen, ex_memrd, ex_memwr = 0; ex_rd = 0; ex_alusel = 3'b000; ex_pc = RESET_PC; all data registers = 0. Reset takes effect mid-cycle without waiting for clk.
- Registered state: valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alusel, asel, bsel, regwen, memrd, memwr.
- Update priority at each posedge, highest first:
  - flush: insert bubble.
  - hold: keep all state.
  - stall_req: insert bubble.
  - Otherwise: load all ID fields.
- Bubble: valid, regwen, memrd, memwr = 0; rd = 0; alusel = 000; data fields may keep stale values.
- Control outputs are gated: ex_regwen, ex_memrd and ex_memwr are forced to 0 whenever ex_valid = 0.
- stall_req (combinational) = ex_valid & ex_memrd & (ex_rd != 0) & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd)) & id_valid.
  - Asserted regardless of hold.
  - During one stall cycle the ID instruction is not captured; it is captured on the following edge.
- Forwarding (combinational, on registered rs1/rs2), applied independently to rs1 and rs2:
  - Source 1: exmem_result if exmem_regwen & exmem_rd != 0 & exmem_rd == rs.
  - Else source 2: memwb_wdata if memwb_regwen & memwb_rd != 0 & memwb_rd == rs.
  - Else the registered register-file data.
  - EX/MEM always wins over MEM/WB. x0 is never forwarded.
- Operand muxes:
  - ex_operand1 = asel ? ex_pc : fwd_rs1.
  - ex_operand2 = bsel ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always, independent of bsel.
- Latency: ID inputs appear on EX outputs 1 cycle after capture. Forwarded values reach operands in the same cycle.
- flush and stall_req together: flush wins; exactly one bubble.
- flush and hold together: flush wins; the EX instruction is killed.

Test Plan:
- Reset: drive rst_n low mid-cycle with ex_valid=1 -> all outputs go to reset values immediately; ex_pc=RESET_PC.
- Basic pass-through: id_rs1_data=5, id_imm=7, bsel=1, alusel=000, id_valid=1 -> next cycle ex_operand1=5, ex_operand2=7, ex_alusel=000, ex_valid=1.
- Forwarding priority:
  - EX rs1=x3; exmem_rd=3, exmem_result=0x11, regwen=1; memwb_rd=3, memwb_wdata=0x22 -> ex_operand1=0x11.
  - Drop exmem_regwen -> ex_operand1=0x22.
  - Set rs1=x0 -> register-file value, no forwarding.
- Load-use: EX holds lw x5 (memrd=1, rd=5), ID add uses rs2=x5 -> stall_req=1 that cycle; next cycle ex_valid=0, ex_regwen=0; following edge the add is captured.
- Flush vs hold: hold=1 for 2 cycles -> outputs unchanged; flush=1 together with hold=1 -> next cycle ex_valid=0, ex_memwr=0.
- Store data: bsel=1, imm=4, rs2=x6 forwarded from memwb (wdata=0xDEAD) -> ex_operand2=4, ex_store_data=0xDEAD.
